phrase_check_arbiter: RTL and testbench
=======================================

PHRASE_CHECK_ARBITER -- requirements
Module: phrase_check_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, means idle cycles before a stalled message is aborted (range 1..65535).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
REQ-004 s0_valid, s0_last / s0_data  input  1,1 / 8  requester 0 character stream: valid, end-of-message, ASCII byte.
REQ-005 s0_ready  output  1  requester 0 beat accepted when s0_valid&&s0_ready.
REQ-006 s1_valid, s1_last / s1_data / s1_ready  in,in / in / out  1,1 / 8 / 1  requester 1 stream, same semantics.
REQ-007 m_valid, m_last / m_data / m_src  output  1,1 / 8 / 1  stream to the shared phrase checker, plus granted requester id.
REQ-008 m_ready  input  1  checker accepts a beat when m_valid&&m_ready.
REQ-009 chk_done, chk_match  input  1,1  checker verdict pulse for the current message; match=1 means "I Love You!" detected.
REQ-010 res_valid, res_src, res_match, res_timeout  output  1 each  one-cycle verdict report routed to the owning requester.

Function
REQ-011 The FSM SHALL have states IDLE, STREAM, WAIT_RES, REPORT, plus ABORT when timeout is compiled in.
REQ-012 IDLE: if any sN_valid, grant SHALL be latched that cycle; next state is STREAM; no beat is accepted in IDLE.
REQ-013 Arbitration SHALL be round-robin per message: on simultaneous requests the requester not granted last wins; the pointer after reset favours requester 0.
REQ-014 STREAM: m_valid/m_data/m_last SHALL combinationally follow the granted source, sN_ready=m_ready for the granted source, 0 for the other.
REQ-015 Grant SHALL be held until a beat with m_last=1 is accepted; the other requester is never passed a beat mid-message.
REQ-016 Accepted last beat -> WAIT_RES; if chk_done is high in that same cycle, the verdict SHALL be captured and the next state is REPORT.
REQ-017 WAIT_RES: all sN_ready=0, m_valid=0; on chk_done capture chk_match -> REPORT; chk_done outside STREAM-last/WAIT_RES SHALL be ignored.
REQ-018 REPORT: res_valid=1 for exactly one cycle with res_src=grant and the captured res_match; round-robin pointer updates; next state is IDLE.
REQ-019 Minimum message turnaround SHALL be: 1 IDLE cycle + N beats + 1 REPORT cycle.
REQ-020 m_src SHALL equal the current grant in STREAM, WAIT_RES and REPORT.

Reset
REQ-021 On reset: state=IDLE, grant=0, RR pointer favours requester 0, m_valid=0, m_last=0, m_data=0, m_src=0, s0_ready=s1_ready=0, res_valid=res_src=res_match=res_timeout=0, timeout counter=0.
REQ-022 Reset mid-message SHALL drop the message silently with no res_valid pulse.

Configuration
REQ-023 Macro PHRASE_ARB_TIMEOUT_EN: when defined, a 16-bit counter SHALL count STREAM cycles with no accepted beat, clearing on every accepted beat.
REQ-024 With the macro defined, the counter reaching TIMEOUT_CYC SHALL move the FSM to ABORT, which drives m_valid=1, m_last=1, m_data=8'h00, sN_ready=0 until m_ready, then goes to WAIT_RES; the following REPORT SHALL set res_timeout=1.
REQ-025 With the macro undefined, there is no counter and no ABORT state, res_timeout is tied 0, and STREAM waits indefinitely.

Structure
REQ-026 A shared package phrase_arb_pkg SHALL hold the state enum, ASCII constants (CHR_NUL=8'h00), and the TIMEOUT_CYC default.
REQ-027 One sub-module, phrase_arb_rr (2-way round-robin pointer and grant logic), SHALL be instantiated; the rest is flat.

Verification
REQ-028 s0 and s1 both valid on the first cycle after reset -> s0 granted, "I Love You!" streamed with m_src=0, chk_done/match=1 -> res_valid one cycle, res_src=0, res_match=1.
REQ-029 Both requesters continuously valid for 4 messages -> grants alternate 0,1,0,1, and no interleaved beats appear on m_data.
REQ-030 m_ready toggled 1,0,1,0 during a message -> no beat is lost or duplicated; the byte order at the checker equals the source order.
REQ-031 chk_done asserted in the same cycle as the last beat accepted -> REPORT on the next cycle, with no stuck state in WAIT_RES.
REQ-032 With PHRASE_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, s1 stalls after "I L" -> at the 8th idle cycle, beat 8'h00 with last=1 is emitted, then res_timeout=1.
REQ-033 rst_n pulsed low mid-message -> all outputs return to reset values, with no res_valid; the next request is granted to requester 0.

Source files
------------

// File: rtl/phrase_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phrase_arb_pkg
// Description : Shared definitions for the phrase-check arbiter. Holds the
//               FSM state encoding, ASCII constants and the default abort
//               timeout. The ABORT state exists only when
//               PHRASE_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package phrase_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STREAM   = 3'd1,
        ST_WAIT_RES = 3'd2,
`ifdef PHRASE_ARB_TIMEOUT_EN
        ST_REPORT   = 3'd3,
        ST_ABORT    = 3'd4
`else
        ST_REPORT   = 3'd3
`endif
    } arb_state_t;

    localparam logic [7:0]  CHR_NUL             = 8'h00;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;
    localparam int          TO_CNT_W            = 16;

endpackage : phrase_arb_pkg
`default_nettype wire

// File: rtl/phrase_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : phrase_arb_rr
// Description : Two-way round-robin pointer and grant selection. The pointer
//               names the requester that wins a tie; it is moved away from
//               the last owner when a message completes.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_req0/i_req1  - request lines
//               i_upd          - message finished, advance pointer
//               i_last_gnt     - owner of the finished message
//               o_gnt          - selected requester id
//               o_any          - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module phrase_arb_rr (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    input  logic i_last_gnt,
    output logic o_gnt,
    output logic o_any
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_upd) begin
            ptr_d = ~i_last_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Tie goes to the pointer; a lone request wins outright.
    assign o_any = i_req0 | i_req1;
    assign o_gnt = (i_req0 && i_req1) ? ptr_q : i_req1;

endmodule : phrase_arb_rr
`default_nettype wire

// File: rtl/phrase_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : phrase_check_arbiter
// Description : Arbitrates two character streams onto one shared phrase
//               checker, one whole message at a time, and routes the
//               checker verdict back as a one-cycle report.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               s0_/s1_ valid,last,data,ready - requester streams
//               m_ valid,last,data,src,ready  - stream to the checker
//               chk_done, chk_match           - checker verdict pulse
//               res_ valid,src,match,timeout  - verdict report
// Config      : PHRASE_ARB_TIMEOUT_EN - when defined, a stalled message is
//               closed with a NUL last beat after TIMEOUT_CYC idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module phrase_check_arbiter
    import phrase_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_valid,
    input  logic       s0_last,
    input  logic [7:0] s0_data,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic       s1_last,
    input  logic [7:0] s1_data,
    output logic       s1_ready,
    output logic       m_valid,
    output logic       m_last,
    output logic [7:0] m_data,
    output logic       m_src,
    input  logic       m_ready,
    input  logic       chk_done,
    input  logic       chk_match,
    output logic       res_valid,
    output logic       res_src,
    output logic       res_match,
    output logic       res_timeout
);

    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout_cfg
        $error("phrase_check_arbiter: TIMEOUT_CYC out of range 1..65535");
    end

    arb_state_t state_q, state_d;
    logic       grant_q, grant_d;
    logic       match_q, match_d;
    logic       rr_gnt, rr_any, rr_upd;

    // Source selected by the current grant.
    logic       sel_valid, sel_last;
    logic [7:0] sel_data;

    assign sel_valid = grant_q ? s1_valid : s0_valid;
    assign sel_last  = grant_q ? s1_last  : s0_last;
    assign sel_data  = grant_q ? s1_data  : s0_data;

    phrase_arb_rr u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req0    (s0_valid),
        .i_req1    (s1_valid),
        .i_upd     (rr_upd),
        .i_last_gnt(grant_q),
        .o_gnt     (rr_gnt),
        .o_any     (rr_any)
    );

`ifdef PHRASE_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC);
    logic [TO_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                to_q, to_d;

    assign cnt_inc = cnt_q + TO_CNT_W'(1);
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        match_d   = match_q;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = CHR_NUL;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        res_valid = 1'b0;
        rr_upd    = 1'b0;
`ifdef PHRASE_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        to_d      = to_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_d = rr_gnt;
                    match_d = 1'b0;
`ifdef PHRASE_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    to_d    = 1'b0;
`endif
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                m_valid  = sel_valid;
                m_last   = sel_last;
                m_data   = sel_data;
                s0_ready = !grant_q && m_ready;
                s1_ready =  grant_q && m_ready;
                if (sel_valid && m_ready) begin
`ifdef PHRASE_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (sel_last) begin
                        // Verdict may arrive together with the last beat.
                        if (chk_done) begin
                            match_d = chk_match;
                            state_d = ST_REPORT;
                        end else begin
                            state_d = ST_WAIT_RES;
                        end
                    end
                end
`ifdef PHRASE_ARB_TIMEOUT_EN
                else if (cnt_inc == TO_LIMIT) begin
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            ST_WAIT_RES: begin
                if (chk_done) begin
                    match_d = chk_match;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                res_valid = 1'b1;
                rr_upd    = 1'b1;
                state_d   = ST_IDLE;
            end
`ifdef PHRASE_ARB_TIMEOUT_EN
            ST_ABORT: begin
                // Synthetic terminator so the checker closes the message.
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data  = CHR_NUL;
                if (m_ready) begin
                    state_d = ST_WAIT_RES;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            match_q <= match_d;
        end
    end

`ifdef PHRASE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign res_timeout = res_valid & to_q;
`else
    assign res_timeout = 1'b0;
`endif

    assign m_src     = grant_q;
    assign res_src   = res_valid & grant_q;
    assign res_match = res_valid & match_q;

endmodule : phrase_check_arbiter
`default_nettype wire

// File: tb/tb_phrase_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_phrase_check_arbiter
// Description : Directed self-checking bench for phrase_check_arbiter.
//               Sources replay queued messages, a checker model judges each
//               collected message, and logs of beats and reports are
//               compared against hand-derived expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phrase_check_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s0_valid, s0_last, s0_ready;
    logic [7:0] s0_data;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] s1_data;
    logic       m_valid, m_last, m_src, m_ready;
    logic [7:0] m_data;
    logic       chk_done, chk_match;
    logic       res_valid, res_src, res_match, res_timeout;

    always #5 clk = ~clk;

    phrase_check_arbiter #(.TIMEOUT_CYC(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_last(s0_last), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_last(s1_last), .s1_data(s1_data), .s1_ready(s1_ready),
        .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_src(m_src), .m_ready(m_ready),
        .chk_done(chk_done), .chk_match(chk_match),
        .res_valid(res_valid), .res_src(res_src), .res_match(res_match),
        .res_timeout(res_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] str2vec(input string s);
        logic [127:0] v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[119:0], s[i]};
        return v;
    endfunction

    // Source and checker-model state
    logic [8:0]   q0[$];
    logic [8:0]   q1[$];
    int           lim1 = -1;
    int           sent1 = 0;
    bit           acc0, acc1;
    bit           mr_toggle = 0;
    int           resp_delay = 0;
    int           pend_cnt = 0;
    bit           pend_match;
    int           cyc = 0;

    // Logs
    logic [127:0] mtext[$];
    bit           msrc[$], mmix[$];
    int           mfirst[$], mlast[$], bcyc[$];
    bit           rsrc[$], rmatch[$], rto[$], rmsrc[$];
    int           rcyc[$];
    logic [127:0] cur_vec;
    bit           cur_open = 0, cur_src, cur_mix;
    int           cur_first;

    task automatic load(input int src, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (src == 0) q0.push_back({(i == s.len() - 1), s[i]});
            else          q1.push_back({(i == s.len() - 1), s[i]});
        end
    endtask

    // Source driver, checker model and monitor
    initial begin
        s0_valid = 0; s0_last = 0; s0_data = 0;
        s1_valid = 0; s1_last = 0; s1_data = 0;
        m_ready = 1; chk_done = 0; chk_match = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) begin void'(q1.pop_front()); sent1++; end
            chk_done = 0; chk_match = 0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin chk_done = 1; chk_match = pend_match; end
            end
            s0_valid = (q0.size() > 0);
            {s0_last, s0_data} = (q0.size() > 0) ? q0[0] : 9'h0;
            s1_valid = (q1.size() > 0) && (lim1 < 0 || sent1 < lim1);
            {s1_last, s1_data} = (q1.size() > 0) ? q1[0] : 9'h0;
            m_ready = mr_toggle ? ~m_ready : 1'b1;
            @(negedge clk);
            acc0 = s0_valid && s0_ready;
            acc1 = s1_valid && s1_ready;
            if (m_valid && m_ready) begin
                bcyc.push_back(cyc);
                if (!cur_open) begin
                    cur_open = 1; cur_src = m_src; cur_mix = 0; cur_vec = '0; cur_first = cyc;
                end else if (m_src != cur_src) begin
                    cur_mix = 1;
                end
                cur_vec = {cur_vec[119:0], m_data};
                if (m_last) begin
                    bit love;
                    love = (cur_vec == str2vec("I Love You!"));
                    mtext.push_back(cur_vec); msrc.push_back(cur_src); mmix.push_back(cur_mix);
                    mfirst.push_back(cur_first); mlast.push_back(cyc);
                    cur_open = 0;
                    if (resp_delay == 0) begin chk_done = 1; chk_match = love; end
                    else begin pend_cnt = resp_delay; pend_match = love; end
                end
            end
            if (res_valid) begin
                rsrc.push_back(res_src); rmatch.push_back(res_match);
                rto.push_back(res_timeout); rmsrc.push_back(m_src); rcyc.push_back(cyc);
            end
        end
    end

    task automatic wait_res(input int n, input int budget);
        int k = 0;
        while (rsrc.size() < n && k < budget) begin @(posedge clk); k++; end
        @(posedge clk); #3;
        check("res_count", rsrc.size(), n);
    endtask

    task automatic chk_rst_outs(input string tag);
        check(tag, {m_valid, m_last, m_data, m_src, s0_ready, s1_ready,
                    res_valid, res_src, res_match, res_timeout}, '0);
    endtask

    initial begin
        string        exp_txt[4];
        bit           exp_m[4];
        logic [127:0] e;
        int           nb, nr, k;
        exp_txt = '{"I Love You!", "I Hate You!", "Hi there", "I Love You!"};
        exp_m   = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n = 0;
        load(0, "I Love You!"); load(0, "Hi there");
        load(1, "I Hate You!"); load(1, "I Love You!");
        repeat (3) @(posedge clk); #3;
        chk_rst_outs("reset_outputs");
        rst_n = 1;

        // Both requesters valid from the first cycle: alternate 0,1,0,1
        wait_res(4, 400);
        for (int i = 0; i < 4 && i < mtext.size() && i < rsrc.size(); i++) begin
            check($sformatf("msg%0d_text", i), mtext[i], str2vec(exp_txt[i]));
            check($sformatf("msg%0d_src", i), msrc[i], i % 2);
            check($sformatf("msg%0d_mix", i), mmix[i], 0);
            check($sformatf("res%0d_src", i), rsrc[i], i % 2);
            check($sformatf("res%0d_msrc", i), rmsrc[i], i % 2);
            check($sformatf("res%0d_match", i), rmatch[i], exp_m[i]);
            check($sformatf("res%0d_timeout", i), rto[i], 0);
        end
        if (rcyc.size() >= 1 && mfirst.size() >= 2) begin
            check("turnaround_same_cycle_done", rcyc[0] - mfirst[0], 11);
            check("idle_gap", mfirst[1] - rcyc[0], 2);
        end

        // m_ready toggling, verdict two cycles after the last beat
        mr_toggle = 1; resp_delay = 2;
        load(1, "I Love You!");
        wait_res(5, 400);
        mr_toggle = 0;
        if (rsrc.size() >= 5 && mtext.size() >= 5) begin
            check("toggle_text", mtext[4], str2vec("I Love You!"));
            check("toggle_span", mlast[4] - mfirst[4], 20);
            check("toggle_src", rsrc[4], 1);
            check("toggle_match", rmatch[4], 1);
            check("wait_res_latency", rcyc[4] - mlast[4], 3);
        end

        // s1 stalls after "I L"
        nb = bcyc.size();
        lim1 = 3; sent1 = 0;
        load(1, "I Love You!");
`ifdef PHRASE_ARB_TIMEOUT_EN
        wait_res(6, 200);
        e = str2vec("I L"); e = {e[119:0], 8'h00};
        if (rsrc.size() >= 6 && mtext.size() >= 6) begin
            check("abort_text", mtext[5], e);
            check("abort_delay", mlast[5] - bcyc[bcyc.size() - 2], 9);
            check("abort_timeout", rto[5], 1);
            check("abort_src", rsrc[5], 1);
            check("abort_match", rmatch[5], 0);
        end
        q1.delete(); lim1 = -1;
`else
        repeat (40) @(posedge clk); #3;
        check("stall_no_res", rsrc.size(), 5);
        check("stall_beats", bcyc.size() - nb, 3);
        lim1 = -1;
        wait_res(6, 200);
        if (rsrc.size() >= 6 && mtext.size() >= 6) begin
            check("stall_resume_text", mtext[5], str2vec("I Love You!"));
            check("stall_timeout", rto[5], 0);
            check("stall_match", rmatch[5], 1);
        end
`endif

        // Reset in the middle of a message
        resp_delay = 0;
        nb = bcyc.size();
        load(1, "I Love You!");
        k = 0;
        while (bcyc.size() < nb + 4 && k < 100) begin @(posedge clk); k++; end
        #3;
        check("mid_beats", bcyc.size() >= nb + 4, 1);
        rst_n = 0;
        q0.delete(); q1.delete(); cur_open = 0; pend_cnt = 0;
        nr = rsrc.size();
        #1;
        chk_rst_outs("mid_reset_outputs");
        repeat (3) @(posedge clk); #3;
        check("mid_reset_no_res", rsrc.size(), nr);
        rst_n = 1;
        load(0, "Hi"); load(1, "Yo");
        wait_res(nr + 2, 200);
        if (rsrc.size() >= nr + 2 && mtext.size() >= 2) begin
            check("post_reset_src0", rsrc[nr], 0);
            check("post_reset_src1", rsrc[nr + 1], 1);
            check("post_reset_text0", mtext[mtext.size() - 2], str2vec("Hi"));
            check("post_reset_text1", mtext[mtext.size() - 1], str2vec("Yo"));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_phrase_check_arbiter
`default_nettype wire
